hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It drives the stall/flush controls of the IF/ID pipeline register, the PC write enable, ID/EX bubble insertion and the EX hold. It resolves taken-branch flushes, load-use hazards, multi-cycle EX operations and instruction-memory wait states. It also keeps saturating stall/flush performance counters and a sticky fetch-timeout error flag.

---
 rtl/hazard_controller.sv | 153 +++++++++++++++
 tb/tb_hazard_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: branch flushes, load-use stalls, multi-cycle EX holds,
// fetch wait states, saturating stall/flush counters and a sticky fetch-timeout flag.
module hazard_controller #(
  parameter int MUL_LATENCY  = 4,
  parameter int IMEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rt_used,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_multi_start,
  input  logic        branch_taken,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_hold,
  output logic        busy,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        imem_error
);

  typedef enum logic [0:0] {RUN = 1'b0, MULTI = 1'b1} state_t;

  // MULTI covers MUL_LATENCY-2 cycles, so the down-counter starts one below that
  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 3);
  localparam logic [7:0] WAIT_MAX = 8'(IMEM_TIMEOUT);

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  wcnt;
  logic        load_use;
  logic        sel_branch;
  logic        sel_multi;
  logic        sel_wait;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_rt_used && (ex_rd == id_rt)));

  // Priority decode of the pipeline controls from state and current inputs
  always_comb begin
    pc_write    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    busy        = 1'b0;
    sel_branch  = 1'b0;
    sel_multi   = 1'b0;
    sel_wait    = 1'b0;
    if (!reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            sel_branch  = 1'b1;
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_multi_start) begin
            sel_multi   = 1'b1;
            if_id_stall = 1'b1;
            ex_hold     = 1'b1;
          end else if (load_use) begin
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            sel_wait    = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
          end
        end
        MULTI: begin
          if_id_stall = 1'b1;
          ex_hold     = 1'b1;
          busy        = 1'b1;
        end
        default: begin
          pc_write    = 1'b0;
        end
      endcase
    end
  end

  // Sequencing FSM for multi-cycle EX operations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (sel_multi && (MUL_LATENCY != 2)) begin
            state <= MULTI;
            cnt   <= CNT_INIT;
          end
        end
        MULTI: begin
          if (cnt == 4'd0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_write && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (sel_branch && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

  // Fetch-wait watchdog; any cycle not selecting the wait rule restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt       <= 8'd0;
      imem_error <= 1'b0;
    end else if (sel_wait) begin
      if (wcnt != WAIT_MAX) begin
        wcnt <= wcnt + 8'd1;
      end
      if (wcnt >= (WAIT_MAX - 8'd1)) begin
        imem_error <= 1'b1;
      end
    end else begin
      wcnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller with an expected-output scoreboard queue.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_rt_used, ex_mem_read, ex_multi_start, branch_taken, imem_ready;
  logic        pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_hold, busy, imem_error;
  logic [15:0] stall_cycles, flush_count;

  hazard_controller #(.MUL_LATENCY(4), .IMEM_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_multi_start(ex_multi_start),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .pc_write(pc_write),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_hold(ex_hold), .busy(busy), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .imem_error(imem_error)
  );

  always #5 clk = ~clk;

  // exp bits: {pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_hold, busy}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_used;
    logic       mem_read;
    logic [4:0] rd;
    logic       multi;
    logic       br;
    logic       ready;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  fails  = 0;
  int  m_stall = 0;
  int  m_flush = 0;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic rt_used,
                              input logic mem_read, input logic [4:0] rd, input logic multi,
                              input logic br, input logic ready, input logic [5:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rt_used = rt_used; v.mem_read = mem_read; v.rd = rd;
    v.multi = multi; v.br = br; v.ready = ready; v.exp = exp;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_rt_used = v.rt_used; ex_mem_read = v.mem_read;
    ex_rd = v.rd; ex_multi_start = v.multi; branch_taken = v.br; imem_ready = v.ready;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge
  task automatic drive(input vec_t v, input string name);
    sb_t        e;
    logic [5:0] act;
    set_inputs(v);
    sb.push_back('{v.exp, name});
    @(negedge clk);
    e   = sb.pop_front();
    act = {pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_hold, busy};
    checks++;
    if (act !== e.exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
    if (!e.exp[5]) m_stall++;
    if (e.exp[5] && e.exp[3]) m_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_hold, busy};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  vec_t  tbl[9];
  string tname[9];
  vec_t  idle, wait_v, br_wait, mstart, mtoggle;

  initial begin
    idle    = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b100000);
    wait_v  = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b001000);
    br_wait = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b101100);
    mstart  = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 6'b010010);
    mtoggle = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 6'b010011);

    tbl[0] = idle;                                                            tname[0] = "idle";
    tbl[1] = mk(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 6'b010100); tname[1] = "loaduse_rs";
    tbl[2] = mk(5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 6'b100000); tname[2] = "load_rd0";
    tbl[3] = mk(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 6'b100000); tname[3] = "load_rt_unused";
    tbl[4] = mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 6'b010100); tname[4] = "loaduse_rt";
    tbl[5] = wait_v;                                                          tname[5] = "imem_wait";
    tbl[6] = mk(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b010100); tname[6] = "loaduse_over_wait";
    tbl[7] = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 6'b101100); tname[7] = "branch_wins_all";
    tbl[8] = idle;                                                            tname[8] = "idle_after_branch";

    // Reset state
    reset = 1'b0;
    set_inputs(idle);
    #12;
    chk_ctrl("reset_ctrl", 6'b001100);
    chk("reset_stall", stall_cycles, 16'd0);
    chk("reset_flush", flush_count, 16'd0);
    chk("reset_err", {15'd0, imem_error}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) drive(tbl[i], tname[i]);
    chk("stall_after_table", stall_cycles, 16'(m_stall));
    chk("flush_after_table", flush_count, 16'(m_flush));

    // Multi-cycle op: hold for 3 cycles, inputs ignored while busy
    drive(mstart, "multi_start");
    drive(mtoggle, "multi_c2");
    drive(mtoggle, "multi_c3");
    drive(idle, "multi_done");
    chk("stall_after_multi", stall_cycles, 16'(m_stall));
    chk("flush_after_multi", flush_count, 16'(m_flush));

    // Fetch timeout: a branch during the wait restarts the count
    for (int i = 0; i < 10; i++) drive(wait_v, "wait_pre");
    drive(br_wait, "wait_branch");
    for (int i = 0; i < 63; i++) drive(wait_v, "wait_63");
    chk("err_after_63", {15'd0, imem_error}, 16'd0);
    drive(wait_v, "wait_64");
    chk("err_after_64", {15'd0, imem_error}, 16'd1);
    drive(idle, "ready_again");
    chk("err_sticky", {15'd0, imem_error}, 16'd1);
    chk("stall_after_wait", stall_cycles, 16'(m_stall));
    chk("flush_after_wait", flush_count, 16'(m_flush));

    // Reset pulse during MULTI cycle 2
    drive(mstart, "multi_start_2");
    chk_ctrl("in_multi_c2", 6'b010011);
    reset = 1'b0;
    #1;
    chk_ctrl("mid_reset_ctrl", 6'b001100);
    chk("mid_reset_stall", stall_cycles, 16'd0);
    chk("mid_reset_flush", flush_count, 16'd0);
    chk("mid_reset_err", {15'd0, imem_error}, 16'd0);
    m_stall = 0;
    m_flush = 0;
    set_inputs(idle);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(idle, "run_after_reset");
    chk("stall_after_reset", stall_cycles, 16'(m_stall));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
